// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divide sequencer.
package div_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // funct3[1:0] encodings: bit0 = unsigned, bit1 = remainder
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    localparam logic [31:0] DIV_MIN_NEG  = 32'h8000_0000;
    localparam logic [31:0] DIV_ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step (purely combinational).
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // The shifted remainder keeps one extra bit so divisors with the MSB set
    // still compare correctly; the borrow of the trial subtraction decides q.
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    assign trial    = {rem, dvd_msb};
    assign diff     = trial - {1'b0, divisor};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Iterative RV32M DIV/DIVU/REM/REMU sequencer for the EX stage.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] MIN_NEG  = DIV_MIN_NEG[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ALL_ONES = DIV_ALL_ONES[WIDTH-1:0];

    div_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] dvd_reg, dvd_next;
    logic [WIDTH-1:0] dvs_reg, dvs_next;
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [1:0]       op_reg, op_next;
    logic             neg_q_reg, neg_q_next;
    logic             neg_r_reg, neg_r_next;

    logic             is_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .dvd_msb  (dvd_reg[WIDTH-1]),
        .divisor  (dvs_reg),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Operand sign handling for the op presented in IDLE
    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & srca[WIDTH-1];
        b_neg     = is_signed & srcb[WIDTH-1];
        abs_a     = a_neg ? (~srca + 1'b1) : srca;
        abs_b     = b_neg ? (~srcb + 1'b1) : srcb;
    end

    // Next-state and datapath update
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rem_next    = rem_reg;
        dvd_next    = dvd_reg;
        dvs_next    = dvs_reg;
        quo_next    = quo_reg;
        result_next = result_reg;
        op_next     = op_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;

        if (flush) begin
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_next    = op;
                        neg_q_next = a_neg ^ b_neg;
                        neg_r_next = a_neg;
                        dvd_next   = abs_a;
                        dvs_next   = abs_b;
                        rem_next   = '0;
                        quo_next   = '0;
                        if (srcb == '0) begin
                            state_next  = DONE;
                            result_next = op[1] ? srca : ALL_ONES;
                        end else if (is_signed && srca == MIN_NEG && srcb == ALL_ONES) begin
                            state_next  = DONE;
                            result_next = op[1] ? '0 : MIN_NEG;
                        end else begin
                            state_next = CALC;
                            cnt_next   = CNT_W'(WIDTH - 1);
                        end
                    end
                end
                CALC: begin
                    rem_next = step_rem;
                    dvd_next = {dvd_reg[WIDTH-2:0], 1'b0};
                    quo_next = {quo_reg[WIDTH-2:0], step_q};
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        state_next = FIX;
                    end
                end
                FIX: begin
                    if (op_reg[1]) begin
                        result_next = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
                    end else begin
                        result_next = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
                    end
                    state_next = DONE;
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            rem_reg    <= '0;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            quo_reg    <= '0;
            result_reg <= '0;
            op_reg     <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rem_reg    <= rem_next;
            dvd_reg    <= dvd_next;
            dvs_reg    <= dvs_next;
            quo_reg    <= quo_next;
            result_reg <= result_next;
            op_reg     <= op_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
        end
    end

    // Pipeline handshake; stall drops in DONE so EX consumes result that cycle
    always_comb begin
        stall  = (state_reg == IDLE && start && !flush) ||
                 state_reg == CALC || state_reg == FIX;
        busy   = (state_reg != IDLE);
        done   = (state_reg == DONE);
        result = result_reg;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Iterative 32-bit integer divide sequencer for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the EX stage beside the ALU.
- Accepts an operation from EX, stalls the pipeline while it iterates with a radix-2 restoring algorithm, then presents the result for one cycle so EX can advance.
- Also applies the RISC-V divide-by-zero and signed-overflow rules.

Parameters:
- WIDTH, 32, operand/result width in bits (iteration count equals WIDTH).
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous active-high reset
- start  input  1  EX holds a divide op; sampled only in IDLE
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- srca  input  WIDTH  dividend (rs1)
- srcb  input  WIDTH  divisor (rs2)
- flush  input  1  EX flush (branch mispredict/kill); aborts op
- stall  output  1  freeze IF/ID/EX while high
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse; result valid
- result  output  WIDTH  quotient or remainder

Behaviour:
- Reset (async, any state):
  - state=IDLE; counter, partial remainder, quotient, result=0.
  - done=0, busy=0, stall=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0 captures op, sign flags, |srca| and |srcb| (absolute values for signed ops; raw values for unsigned).
  - srcb==0: next state DONE. result = all-ones for DIV/DIVU, srca for REM/REMU.
  - Signed op with srca==0x80000000 and srcb==0xFFFFFFFF: next state DONE. result = 0x80000000 for DIV, 0 for REM.
  - Otherwise: next state CALC, counter=WIDTH-1.
- CALC, one restoring step per cycle:
  - rem = {rem[W-2:0], dvd[W-1]}; shift dividend left.
  - If rem>=divisor: subtract and shift in q=1; else shift in q=0.
  - Counter decrements; counter==0 moves to FIX.
- FIX:
  - Quotient negated if signed and sign(srca)!=sign(srcb).
  - Remainder negated if signed and srca negative.
  - Result register loaded per op; next state DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- Latency, start sampled at edge T:
  - Normal: done high in cycle T+WIDTH+2 (34 cycles for WIDTH=32).
  - Special cases: done high in cycle T+1.
- stall = (state==IDLE & start & ~flush) | state==CALC | state==FIX.
  - stall is low in DONE so EX advances with result the same cycle.
- result holds its last value after DONE until the next FIX or special-case capture.
- flush:
  - Synchronous. In any state, next state is IDLE, no done pulse, result unchanged.
  - flush and start in the same IDLE cycle: flush wins, nothing captured.
- Operands are only sampled at start; srca/srcb changes during CALC have no effect.
- Back-to-back divides: the second start is sampled in the IDLE cycle after DONE.

Decomposition:
- Shared package div_pkg:
  - div_state_t enum (IDLE, CALC, FIX, DONE).
  - op encodings DIV_OP_DIV/DIVU/REM/REMU.
  - Constants DIV_MIN_NEG=0x80000000 and DIV_ALL_ONES.
- Sub-module div_step: combinational single restoring step.
  - Inputs: rem, dividend MSB, divisor.
  - Outputs: next rem, quotient bit.

Test Plan:
- DIVU 100/7 with start pulse at T -> stall high T..T+33, done at T+34, result=14; REMU same operands -> result=2.
- DIV -7/2 -> result=0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
- DIVU 5/0 -> done at T+1, result=0xFFFFFFFF; REM 5/0 -> result=5.
- DIV 0x80000000/0xFFFFFFFF -> done at T+1, result=0x80000000; REM same -> 0.
- Flush asserted at CALC iteration 10 -> IDLE next cycle, no done, stall low, prior result retained; new DIVU 9/3 then completes with 3.
- reset asserted mid-CALC (asynchronous, between edges) -> busy/stall/done/result=0 immediately; back-to-back DIVU 20/4 then REMU 20/6 -> 5 then 2, each with a single done pulse.
